conv_frame_streamer: RTL and testbench
======================================

Name: conv_frame_streamer

Overview:
Frame-side driver for conv_top. It holds one IMG_W x IMG_H frame and a 3x3 kernel loaded by the host. On start it streams the frame in raster order onto conv_top's pixel_valid/pixel_in and drives kernel_in. It then counts the conv_valid pulses returned by conv_top and signals completion, or a timeout if outputs stop arriving.

Parameters:
IMG_W, 8, frame width in pixels (>=3)
IMG_H, 8, frame height in pixels (>=3)
TIMEOUT, 64, maximum idle cycles without conv_valid while in DRAIN before aborting
(local) NPIX = IMG_W*IMG_H; OUT_CNT = (IMG_W-2)*(IMG_H-2); AW = clog2(NPIX)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
ld_en  in  1  frame RAM write strobe
ld_addr  in  AW  frame RAM write address, raster index
ld_data  in  8  pixel byte to write
kern_we  in  1  kernel register write strobe
kern_data  in  72  9 packed signed 8-bit taps, row-major, tap0 in [71:64]
start  in  1  begin one frame pass (level sampled)
hold  in  1  stall the pixel stream
conv_valid  in  1  output strobe returned from conv_top
pixel_valid  out  1  to conv_top.pixel_valid
pixel_data  out  8  to conv_top.pixel_in
kernel_out  out  72  to conv_top.kernel_in
busy  out  1  frame pass in progress
done  out  1  one-cycle completion pulse
out_count  out  16  conv_valid pulses counted this pass
timeout_err  out  1  last pass ended by timeout

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; pixel_valid, pixel_data, kernel_out, busy, done, out_count and timeout_err all 0; read address 0; frame RAM contents undefined. Any pass in progress is aborted with no done pulse.
- Frame RAM: NPIX x 8, one write port, synchronous write. A write takes effect only when ld_en=1 and busy=0; otherwise it is dropped.
- Kernel: kernel_out <= kern_data on an edge with kern_we=1 and busy=0; otherwise it holds, and it is stable for a whole pass.
- FSM states are IDLE, STREAM, DRAIN and DONE.
- IDLE to STREAM: on an edge with start=1 and ld_en=0.
  - busy=1 from that edge.
  - Read address cleared to 0; out_count and timeout_err cleared.
  - start while busy is ignored.
- STREAM, on each edge:
  - hold=0: pixel_valid<=1, pixel_data<=mem[addr], addr increments.
  - hold=1: pixel_valid<=0, pixel_data holds, addr frozen.
  - The first pixel appears 1 edge after start is sampled.
  - After the edge that issues addr NPIX-1, go to DRAIN; pixel_valid<=0 on the next edge.
  - Pixels leave strictly in order 0..NPIX-1, with no duplicates or skips across hold gaps.
- DRAIN:
  - The idle counter increments each edge with conv_valid=0 and resets to 0 on conv_valid=1.
  - out_count reaching OUT_CNT: go to DONE.
  - Idle counter reaching TIMEOUT: go to DONE and set timeout_err=1.
- Output counting:
  - out_count increments on every conv_valid=1 during STREAM and DRAIN and saturates at 16'hFFFF.
  - conv_valid in IDLE or DONE is ignored.
  - If out_count reaches OUT_CNT while still in STREAM, streaming completes first, then DRAIN exits on its next edge.
- DONE: done=1 for exactly one cycle, busy=0 from the same edge, then IDLE. out_count and timeout_err hold until the next accepted start.
- Simultaneous events:
  - start together with ld_en in IDLE: the write wins and start is ignored.
  - kern_we together with start: the kernel is written and the pass starts on the same edge.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
1. Load mem[i]=i for i=0..63 and kernel {FF,00,01,FE,00,02,FF,00,01}, pulse start, then return 36 conv_valid pulses -> 64 consecutive pixel_valid cycles with data 0..63, the first 1 edge after start. kernel_out matches the loaded value. done pulses once, out_count=36, timeout_err=0.
2. Same frame with hold=1 for 3 edges when pixel 20 is next -> pixel_valid low for exactly 3 cycles, then resumes at 20. Full sequence 0..63 intact, 67 streaming cycles total.
3. Stream with conv_valid tied to 0 -> DRAIN waits exactly 64 edges, then done=1, timeout_err=1, out_count=0. The next start clears timeout_err.
4. While busy, apply ld_en (addr 5, data 8'hAA), kern_we (all-zero taps) and start -> no effect. The next pass streams mem[5]=5 and kernel_out is unchanged.
5. Drive rst=0 between clock edges while streaming pixel 30 -> all outputs 0 immediately. After release, start streams from pixel 0.
6. 40 conv_valid pulses in DRAIN with OUT_CNT=36 -> DONE after the 36th, out_count=36; the later pulses are ignored.

Source files
------------

// File: rtl/conv_frame_streamer_if.sv
// Conv-side link between the frame streamer (master) and conv_top (slave).
// Carries the pixel stream and kernel taps out and the conv_valid strobe back.
interface conv_frame_streamer_if;
    logic        pixel_valid;
    logic [7:0]  pixel_data;
    logic [71:0] kernel_out;
    logic        conv_valid;

    modport master (
        output pixel_valid,
        output pixel_data,
        output kernel_out,
        input  conv_valid
    );

    modport slave (
        input  pixel_valid,
        input  pixel_data,
        input  kernel_out,
        output conv_valid
    );
endinterface

// File: rtl/conv_frame_streamer.sv
// Frame-side driver for conv_top: holds one frame and a 3x3 kernel, streams the
// frame in raster order on start, then counts returned conv_valid strobes.
module conv_frame_streamer #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int TIMEOUT = 64,
    localparam int NPIX   = IMG_W * IMG_H,
    localparam int AW     = $clog2(NPIX)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ld_en_i,
    input  logic [AW-1:0]         ld_addr_i,
    input  logic [7:0]            ld_data_i,
    input  logic                  kern_we_i,
    input  logic [71:0]           kern_data_i,
    input  logic                  start_i,
    input  logic                  hold_i,
    conv_frame_streamer_if.master conv_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           out_count_o,
    output logic                  timeout_err_o
);

    localparam int OUT_CNT = (IMG_W - 2) * (IMG_H - 2);
    localparam int IW      = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] LAST_ADDR  = AW'(NPIX - 1);
    localparam logic [15:0]   OUT_TARGET = 16'(OUT_CNT);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pixel_valid_q, pixel_valid_d;
    logic [7:0]    pixel_data_q, pixel_data_d;
    logic [71:0]   kernel_q, kernel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   out_count_q, out_count_d;
    logic          timeout_err_q, timeout_err_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [15:0]   count_inc;

    logic [7:0]    mem_q [NPIX];

    // Host writes are locked out for the whole pass so the frame cannot change mid-stream.
    always_ff @(posedge clk_i) begin
        if (ld_en_i && !busy_q) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
    end

    assign count_inc = (out_count_q == 16'hFFFF) ? out_count_q : out_count_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        pixel_valid_d = 1'b0;
        pixel_data_d  = pixel_data_q;
        kernel_d      = kernel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        out_count_d   = out_count_q;
        timeout_err_d = timeout_err_q;
        idle_d        = idle_q;

        if (kern_we_i && !busy_q) begin
            kernel_d = kern_data_i;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !ld_en_i) begin
                    state_d       = S_STREAM;
                    busy_d        = 1'b1;
                    addr_d        = '0;
                    out_count_d   = '0;
                    timeout_err_d = 1'b0;
                    idle_d        = '0;
                end
            end

            S_STREAM: begin
                if (conv_if.conv_valid) begin
                    out_count_d = count_inc;
                end
                if (!hold_i) begin
                    pixel_valid_d = 1'b1;
                    pixel_data_d  = mem_q[addr_q];
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end

            // A count already reached during STREAM makes the first DRAIN edge exit.
            S_DRAIN: begin
                if (conv_if.conv_valid) begin
                    out_count_d = count_inc;
                    idle_d      = '0;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
                if (out_count_d >= OUT_TARGET) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (idle_d == IDLE_LIMIT) begin
                    state_d       = S_DONE;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    timeout_err_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            kernel_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            out_count_q   <= '0;
            timeout_err_q <= 1'b0;
            idle_q        <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            kernel_q      <= kernel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            out_count_q   <= out_count_d;
            timeout_err_q <= timeout_err_d;
            idle_q        <= idle_d;
        end
    end

    assign conv_if.pixel_valid = pixel_valid_q;
    assign conv_if.pixel_data  = pixel_data_q;
    assign conv_if.kernel_out  = kernel_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign out_count_o         = out_count_q;
    assign timeout_err_o       = timeout_err_q;

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Bench for conv_frame_streamer: a vector table for the start of a pass, directed
// corner-case sequences, and randomized passes checked against a frame-level model.
module tb_conv_frame_streamer;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int TMO  = 64;
    localparam int NPIX = W * H;
    localparam int OUTC = (W - 2) * (H - 2);
    localparam int AW   = $clog2(NPIX);

    logic          clk = 1'b0;
    logic          rstN;
    logic          ldEn;
    logic [AW-1:0] ldAddr;
    logic [7:0]    ldData;
    logic          kernWe;
    logic [71:0]   kernData;
    logic          startIn;
    logic          holdIn;
    logic          convValid;
    logic          busy;
    logic          done;
    logic [15:0]   outCount;
    logic          timeoutErr;

    conv_frame_streamer_if convIf ();
    assign convIf.conv_valid = convValid;

    conv_frame_streamer #(
        .IMG_W   (W),
        .IMG_H   (H),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .ld_en_i       (ldEn),
        .ld_addr_i     (ldAddr),
        .ld_data_i     (ldData),
        .kern_we_i     (kernWe),
        .kern_data_i   (kernData),
        .start_i       (startIn),
        .hold_i        (holdIn),
        .conv_if       (convIf),
        .busy_o        (busy),
        .done_o        (done),
        .out_count_o   (outCount),
        .timeout_err_o (timeoutErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic          hold;
        logic          ldEn;
        logic [AW-1:0] ldAddr;
        logic [7:0]    ldData;
        logic          kernWe;
        logic          expBusy;
        logic          expPv;
        logic [7:0]    expData;
    } vec_t;

    vec_t vecs [11];

    int checkCount = 0;
    int passCount  = 0;
    int edgeNo     = 0;

    logic [7:0]  refMem [NPIX];
    logic [71:0] refKern;
    logic [7:0]  captured [$];
    int          pixEdge [$];
    int          firstPixEdge, lastPixEdge, doneEdge, doneCount;
    int          startEdge, pulseEdge, issued, holdsInStream;

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edgeNo++;
        if (convIf.pixel_valid) begin
            if (captured.size() == 0) firstPixEdge = edgeNo;
            captured.push_back(convIf.pixel_data);
            pixEdge.push_back(edgeNo);
            lastPixEdge = edgeNo;
        end
        if (done) begin
            doneCount++;
            doneEdge = edgeNo;
        end
    endtask

    // Records what the inputs about to be sampled mean for the pass, in frame-level terms.
    task automatic noteDrive();
        if (startIn && !ldEn && !busy) startEdge = edgeNo + 1;
        if (holdIn && busy && captured.size() > 0 && captured.size() < NPIX) holdsInStream++;
        if (convValid && busy) begin
            issued++;
            if (issued == OUTC) pulseEdge = edgeNo + 1;
        end
    endtask

    task automatic idleInputs();
        ldEn = 1'b0; ldAddr = '0; ldData = '0; kernWe = 1'b0; kernData = '0;
        startIn = 1'b0; holdIn = 1'b0; convValid = 1'b0;
    endtask

    task automatic resetPassStats();
        captured.delete();
        pixEdge.delete();
        firstPixEdge = -1; lastPixEdge = -1; doneEdge = -1; doneCount = 0;
        startEdge = -1; pulseEdge = -1; issued = 0; holdsInStream = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        startIn = v.start; holdIn = v.hold; ldEn = v.ldEn; ldAddr = v.ldAddr;
        ldData = v.ldData; kernWe = v.kernWe; kernData = '0; convValid = 1'b0;
        noteDrive();
        tick();
        idleInputs();
    endtask

    task automatic loadFrame(input bit randomData);
        for (int i = 0; i < NPIX; i++) begin
            ldEn   = 1'b1;
            ldAddr = AW'(i);
            ldData = randomData ? 8'($urandom_range(255)) : 8'(i);
            refMem[i] = ldData;
            tick();
        end
        idleInputs();
    endtask

    task automatic loadKernel(input logic [71:0] k);
        kernWe = 1'b1; kernData = k; refKern = k;
        tick();
        idleInputs();
    endtask

    task automatic startPass(input bit withKern, input logic [71:0] k);
        resetPassStats();
        startIn = 1'b1;
        if (withKern) begin
            kernWe = 1'b1; kernData = k; refKern = k;
        end
        noteDrive();
        tick();
        idleInputs();
        checkValue("start.busy", int'(busy), 1);
        checkValue("start.timeoutClear", int'(timeoutErr), 0);
        checkValue("start.countClear", int'(outCount), 0);
    endtask

    // holdMode: 0 none, 1 three holds with pixel 20 next, 2 random.
    // cvMode: 0 none, 1 random until OUTC, 2 burst of burstLen after the last pixel.
    task automatic runRest(input int holdMode, input int cvMode, input int burstLen);
        int holdLeft = 3;
        int burstSent = 0;
        for (int cyc = 0; cyc < 3000 && doneCount == 0; cyc++) begin
            holdIn = 1'b0; convValid = 1'b0;
            if (holdMode == 1 && captured.size() == 20 && holdLeft > 0) begin
                holdIn = 1'b1; holdLeft--;
            end else if (holdMode == 2 && captured.size() > 0 && $urandom_range(3) == 0) begin
                holdIn = 1'b1;
            end
            if (cvMode == 1 && issued < OUTC && busy && $urandom_range(99) < 40) convValid = 1'b1;
            if (cvMode == 2 && captured.size() == NPIX && burstSent < burstLen) begin
                convValid = 1'b1; burstSent++;
            end
            noteDrive();
            tick();
        end
        if (doneCount == 0) checkValue("pass.doneReached", 0, 1);
        idleInputs();
    endtask

    task automatic verifyPass(input string tag, input bit expTmo);
        int errs = 0;
        int expDone;
        int expCount = expTmo ? 0 : OUTC;
        checkValue({tag, ".pixCount"}, captured.size(), NPIX);
        for (int i = 0; i < captured.size() && i < NPIX; i++)
            if (captured[i] !== refMem[i]) errs++;
        checkValue({tag, ".pixOrder"}, errs, 0);
        checkValue({tag, ".firstLatency"}, firstPixEdge - startEdge, 1);
        checkValue({tag, ".span"}, lastPixEdge - firstPixEdge + 1, NPIX + holdsInStream);
        if (expTmo) expDone = lastPixEdge + TMO;
        else expDone = (pulseEdge > lastPixEdge + 1) ? pulseEdge : lastPixEdge + 1;
        checkValue({tag, ".doneEdge"}, doneEdge, expDone);
        checkValue({tag, ".doneCount"}, doneCount, 1);
        checkValue({tag, ".outCount"}, int'(outCount), expCount);
        checkValue({tag, ".timeoutErr"}, int'(timeoutErr), int'(expTmo));
        checkValue({tag, ".busyLow"}, int'(busy), 0);
        checkOutput({tag, ".kernel"}, convIf.kernel_out, refKern);
        tick();
        checkValue({tag, ".donePulse"}, int'(done), 0);
        checkValue({tag, ".countHold"}, int'(outCount), expCount);
        checkValue({tag, ".tmoHold"}, int'(timeoutErr), int'(expTmo));
    endtask

    initial begin
        logic [7:0]  v7;
        logic [71:0] kRand;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b1, 8'd1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b1, 8'd2};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, AW'(5), 8'hAA, 1'b0, 1'b1, 1'b1, 8'd3};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, AW'(0), 8'h00, 1'b1, 1'b1, 1'b1, 8'd4};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b0, 8'd4};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, AW'(5), 8'hAA, 1'b0, 1'b1, 1'b0, 8'd4};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b1, 8'd5};
        vecs[10] = '{1'b0, 1'b0, 1'b0, AW'(0), 8'h00, 1'b0, 1'b1, 1'b1, 8'd6};

        idleInputs();
        resetPassStats();
        refKern = '0;
        rstN = 1'b0;
        #3;
        checkValue("reset.busy", int'(busy), 0);
        checkValue("reset.pixelValid", int'(convIf.pixel_valid), 0);
        checkValue("reset.pixelData", int'(convIf.pixel_data), 0);
        checkOutput("reset.kernel", convIf.kernel_out, 72'h0);
        checkValue("reset.done", int'(done), 0);
        checkValue("reset.outCount", int'(outCount), 0);
        checkValue("reset.timeoutErr", int'(timeoutErr), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Identity frame plus the reference kernel, then the table drives the pass start.
        loadFrame(1'b0);
        loadKernel(72'hFF0001FE0002FF0001);
        resetPassStats();
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkValue($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].expBusy));
            checkValue($sformatf("vec%0d.pv", i), int'(convIf.pixel_valid), int'(vecs[i].expPv));
            checkValue($sformatf("vec%0d.data", i), int'(convIf.pixel_data), int'(vecs[i].expData));
        end
        runRest(0, 2, OUTC);
        verifyPass("basic", 1'b0);

        startPass(1'b0, '0);
        runRest(1, 1, 0);
        verifyPass("hold20", 1'b0);
        checkValue("hold20.span67", lastPixEdge - firstPixEdge + 1, NPIX + 3);
        if (pixEdge.size() > 20) checkValue("hold20.gap", pixEdge[20] - pixEdge[19], 4);
        else checkValue("hold20.gapSeen", pixEdge.size(), NPIX);

        startPass(1'b0, '0);
        runRest(0, 0, 0);
        verifyPass("timeout", 1'b1);

        startPass(1'b0, '0);
        runRest(0, 2, 40);
        verifyPass("extraPulses", 1'b0);
        for (int i = 0; i < 4; i++) begin
            convValid = 1'b1;
            tick();
        end
        idleInputs();
        checkValue("extraPulses.countAfter", int'(outCount), OUTC);
        checkValue("extraPulses.singleDone", doneCount, 1);

        // Asynchronous reset in the middle of a pass, between clock edges.
        startPass(1'b0, '0);
        for (int c = 0; c < 200 && captured.size() < 31; c++) begin
            noteDrive();
            tick();
        end
        checkValue("midReset.reached30", captured.size(), 31);
        if (captured.size() == 31) checkValue("midReset.pix30", int'(captured[30]), int'(refMem[30]));
        #2 rstN = 1'b0;
        #1;
        checkValue("midReset.busy", int'(busy), 0);
        checkValue("midReset.pixelValid", int'(convIf.pixel_valid), 0);
        checkValue("midReset.pixelData", int'(convIf.pixel_data), 0);
        checkOutput("midReset.kernel", convIf.kernel_out, 72'h0);
        checkValue("midReset.done", int'(done), 0);
        checkValue("midReset.outCount", int'(outCount), 0);
        #20 rstN = 1'b1;
        refKern = '0;
        loadFrame(1'b1);
        startPass(1'b0, '0);
        runRest(0, 1, 0);
        verifyPass("afterReset", 1'b0);

        // Load and start on the same edge: the write wins and no pass begins.
        v7 = 8'($urandom_range(255));
        ldEn = 1'b1; ldAddr = AW'(7); ldData = v7; startIn = 1'b1;
        refMem[7] = v7;
        noteDrive();
        tick();
        idleInputs();
        checkValue("ldStart.busy", int'(busy), 0);
        tick();
        checkValue("ldStart.stillIdle", int'(busy), 0);

        for (int p = 0; p < 3; p++) begin
            if (p > 0) loadFrame(1'b1);
            kRand = {8'($urandom), 32'($urandom), 32'($urandom)};
            startPass(1'b1, kRand);
            runRest(2, 1, 0);
            verifyPass($sformatf("rand%0d", p), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
